evr_tx_framer: RTL and testbench

- Downstream stage of tx_buffer, in the tx_clk domain.
- Builds the 8-bit-per-clock EVR transmit stream for the GT: even byte = event code or K28.5 comma; odd byte alternates between distributed-bus byte and data-buffer byte.
- Generates tx_odd for tx_buffer, consumes its tx_data/tx_charisk/tx_ready bytes, and strobes tx_take when a byte is used.

---
 rtl/evr_tx_framer_if.sv | 24 ++
 rtl/evr_tx_framer.sv | 129 ++++++++++++
 tb/tb_evr_tx_framer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/evr_tx_framer_if.sv
// Handshake bundle between evr_tx_framer and its upstream producers:
// the tx_buffer byte handshake and the user event handshake.
interface evr_tx_framer_if;
  logic       tx_odd;
  logic [7:0] tx_data;
  logic       tx_charisk;
  logic       tx_ready;
  logic       tx_take;
  logic [7:0] ev_code;
  logic       ev_valid;
  logic       ev_ready;

  // Framer side
  modport master (
    output tx_odd, tx_take, ev_ready,
    input  tx_data, tx_charisk, tx_ready, ev_code, ev_valid
  );

  // Producer side (tx_buffer and event source)
  modport slave (
    input  tx_odd, tx_take, ev_ready,
    output tx_data, tx_charisk, tx_ready, ev_code, ev_valid
  );
endinterface

// File: rtl/evr_tx_framer.sv
// EVR transmit framer: builds the byte stream for the GT. Even bytes carry
// an event code, heartbeat or K28.5 comma; odd bytes alternate between the
// distributed bus and the tx_buffer data stream.
module evr_tx_framer #(
  parameter logic [31:0] HB_PERIOD = 32'd125000,
  parameter logic [7:0]  HB_CODE   = 8'h7A,
  parameter logic [7:0]  IDLE_DATA = 8'h00
) (
  input  logic                  tx_clk,
  input  logic                  aresetn,
  evr_tx_framer_if.master       link,
  input  logic [7:0]            dbus,
  output logic [7:0]            gt_txdata,
  output logic                  gt_txcharisk,
  output logic [31:0]           ev_sent_cnt
);

  localparam logic [0:0] SLOT_DBUS = 1'b0;
  localparam logic [0:0] SLOT_BUF  = 1'b1;
  localparam logic [7:0] K28_5     = 8'hBC;

  logic        odd;
  logic [0:0]  slot;
  logic        hold_full;
  logic [7:0]  hold_code;
  logic        hb_pending;
  logic [31:0] hb_cnt;

  logic        emit_ev;
  logic        emit_hb;
  logic        ev_ready_int;
  logic        accept;
  logic        take;
  logic        hb_expire;
  logic [7:0]  next_data;
  logic        next_k;

  // Slot decode, handshakes and selection of the byte for the next edge
  always_comb begin
    emit_ev      = !odd && hold_full;
    emit_hb      = !odd && !hold_full && hb_pending;
    ev_ready_int = !hold_full || emit_ev;
    accept       = link.ev_valid && ev_ready_int && (link.ev_code != '0);
    take         = odd && (slot == SLOT_BUF) && link.tx_ready;
    hb_expire    = (HB_PERIOD != '0) && odd && (hb_cnt == HB_PERIOD - 32'd1);
    next_data    = K28_5;
    next_k       = 1'b1;
    if (!odd) begin
      if (emit_ev) begin
        next_data = hold_code;
        next_k    = 1'b0;
      end else if (emit_hb) begin
        next_data = HB_CODE;
        next_k    = 1'b0;
      end
    end else if (slot == SLOT_DBUS) begin
      next_data = dbus;
      next_k    = 1'b0;
    end else if (link.tx_ready) begin
      next_data = link.tx_data;
      next_k    = link.tx_charisk;
    end else begin
      next_data = IDLE_DATA;
      next_k    = 1'b0;
    end
  end

  // tx_take is combinational so an asynchronous reset withdraws it at once
  assign link.tx_odd   = odd;
  assign link.tx_take  = take;
  assign link.ev_ready = ev_ready_int;

  // Byte phase and odd-slot select: phase toggles every cycle, slot after each odd cycle
  always_ff @(posedge tx_clk or negedge aresetn) begin
    if (!aresetn) begin
      odd  <= 1'b0;
      slot <= SLOT_DBUS;
    end else begin
      odd <= !odd;
      if (odd) slot <= (slot == SLOT_DBUS) ? SLOT_BUF : SLOT_DBUS;
    end
  end

  // One-deep event holding register; an emit and a new accept may share a cycle
  always_ff @(posedge tx_clk or negedge aresetn) begin
    if (!aresetn) begin
      hold_full   <= 1'b0;
      hold_code   <= '0;
      ev_sent_cnt <= '0;
    end else begin
      if (emit_ev) begin
        hold_full   <= 1'b0;
        ev_sent_cnt <= ev_sent_cnt + 32'd1;
      end
      if (accept) begin
        hold_full <= 1'b1;
        hold_code <= link.ev_code;
      end
    end
  end

  // Heartbeat timer: one tick per frame; a pending beat waits behind user events
  always_ff @(posedge tx_clk or negedge aresetn) begin
    if (!aresetn) begin
      hb_cnt     <= '0;
      hb_pending <= 1'b0;
    end else begin
      if (emit_hb) hb_pending <= 1'b0;
      if (hb_expire) begin
        hb_cnt     <= '0;
        hb_pending <= 1'b1;
      end else if ((HB_PERIOD != '0) && odd) begin
        hb_cnt <= hb_cnt + 32'd1;
      end
    end
  end

  // Registered GT outputs; reset forces K28.5 comma
  always_ff @(posedge tx_clk or negedge aresetn) begin
    if (!aresetn) begin
      gt_txdata    <= K28_5;
      gt_txcharisk <= 1'b1;
    end else begin
      gt_txdata    <= next_data;
      gt_txcharisk <= next_k;
    end
  end

endmodule

// File: tb/tb_evr_tx_framer.sv
// Directed, scoreboard-checked bench for evr_tx_framer. Two instances: one
// with heartbeat disabled for the main tests, one with HB_PERIOD=4.
module tb_evr_tx_framer;

  typedef struct packed {
    logic [7:0] d;
    logic       k;
  } byte_t;

  logic        tx_clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_charisk = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  ev_code = '0;
  logic        ev_valid = 1'b0;
  logic [7:0]  dbus = '0;

  logic [7:0]  gm_data, gh_data;
  logic        gm_k, gh_k;
  logic [31:0] gm_cnt, gh_cnt;

  logic [7:0]  s_data;
  logic        s_k, s_odd, s_take, s_ready;
  logic [31:0] s_cnt;

  bit          sel_hb = 1'b0;
  bit          mon_en = 1'b0;
  bit          b_odd = 1'b0;
  bit          b_buf = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned takes_seen = 0;
  byte_t       exp_q[$];
  byte_t       bufq[$];
  byte_t       mon_e;

  always #5 tx_clk = ~tx_clk;

  evr_tx_framer_if ifm();
  evr_tx_framer_if ifh();

  assign ifm.tx_data    = tx_data;
  assign ifm.tx_charisk = tx_charisk;
  assign ifm.tx_ready   = tx_ready;
  assign ifm.ev_code    = ev_code;
  assign ifm.ev_valid   = ev_valid;
  assign ifh.tx_data    = tx_data;
  assign ifh.tx_charisk = tx_charisk;
  assign ifh.tx_ready   = tx_ready;
  assign ifh.ev_code    = ev_code;
  assign ifh.ev_valid   = ev_valid;

  evr_tx_framer #(.HB_PERIOD(32'd0), .HB_CODE(8'h7A), .IDLE_DATA(8'h00)) u_main (
    .tx_clk      (tx_clk),
    .aresetn     (aresetn),
    .link        (ifm),
    .dbus        (dbus),
    .gt_txdata   (gm_data),
    .gt_txcharisk(gm_k),
    .ev_sent_cnt (gm_cnt)
  );

  evr_tx_framer #(.HB_PERIOD(32'd4), .HB_CODE(8'h7A), .IDLE_DATA(8'h00)) u_hb (
    .tx_clk      (tx_clk),
    .aresetn     (aresetn),
    .link        (ifh),
    .dbus        (dbus),
    .gt_txdata   (gh_data),
    .gt_txcharisk(gh_k),
    .ev_sent_cnt (gh_cnt)
  );

  always_comb begin
    s_data  = sel_hb ? gh_data        : gm_data;
    s_k     = sel_hb ? gh_k           : gm_k;
    s_cnt   = sel_hb ? gh_cnt         : gm_cnt;
    s_odd   = sel_hb ? ifh.tx_odd     : ifm.tx_odd;
    s_take  = sel_hb ? ifh.tx_take    : ifm.tx_take;
    s_ready = sel_hb ? ifh.ev_ready   : ifm.ev_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: each registered GT byte is compared with the oldest expectation
  always @(posedge tx_clk) begin
    if (mon_en) begin
      #1;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("gt_txdata", 32'(s_data), 32'(mon_e.d));
        chk("gt_txcharisk", 32'(s_k), 32'(mon_e.k));
      end
    end
  end

  // Upstream tx_buffer model: head of bufq is presented until taken
  task automatic present_buf();
    if (bufq.size() != 0) begin
      tx_ready   = 1'b1;
      tx_data    = bufq[0].d;
      tx_charisk = bufq[0].k;
    end else begin
      tx_ready   = 1'b0;
      tx_data    = '0;
      tx_charisk = 1'b0;
    end
  endtask

  // One byte cycle: push the expected byte, check phase/take/ready, advance
  task automatic step(input bit ov, input logic [7:0] od, input logic ok, input int er);
    byte_t e;
    logic  tk;
    #1;
    chk("tx_odd", 32'(s_odd), 32'(b_odd));
    tk = 1'b0;
    if (!b_odd) e = ov ? {od, ok} : {8'hBC, 1'b1};
    else if (!b_buf) e = {dbus, 1'b0};
    else if (tx_ready) begin
      e  = {tx_data, tx_charisk};
      tk = 1'b1;
    end else e = {8'h00, 1'b0};
    chk("tx_take", 32'(s_take), 32'(tk));
    if (s_take) takes_seen++;
    if (er >= 0) chk("ev_ready", 32'(s_ready), 32'(er));
    exp_q.push_back(e);
    @(negedge tx_clk);
    if (tk) void'(bufq.pop_front());
    if (b_odd) b_buf = !b_buf;
    b_odd = !b_odd;
    dbus = 8'($urandom);
    present_buf();
  endtask

  task automatic do_reset();
    mon_en   = 1'b0;
    aresetn  = 1'b0;
    ev_valid = 1'b0;
    ev_code  = '0;
    repeat (10) @(negedge tx_clk);
    #1;
    chk("rst_gt_txdata", 32'(s_data), 32'hBC);
    chk("rst_gt_txcharisk", 32'(s_k), 32'd1);
    chk("rst_tx_odd", 32'(s_odd), 32'd0);
    chk("rst_tx_take", 32'(s_take), 32'd0);
    chk("rst_ev_ready", 32'(s_ready), 32'd1);
    chk("rst_ev_sent_cnt", s_cnt, 32'd0);
    exp_q.delete();
    aresetn = 1'b1;
    b_odd   = 1'b0;
    b_buf   = 1'b0;
    mon_en  = 1'b1;
  endtask

  initial begin
    dbus = 8'h5C;
    present_buf();

    // Reset and idle stream
    sel_hb = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b0, 1);

    // Single event, then a zero code which must be discarded
    do_reset();
    ev_valid = 1'b1; ev_code = 8'h01;
    step(1'b0, 8'h00, 1'b0, 1);
    ev_valid = 1'b0; ev_code = 8'h00;
    step(1'b0, 8'h00, 1'b0, 0);
    step(1'b1, 8'h01, 1'b0, 1);
    chk("ev_sent_cnt_single", s_cnt, 32'd1);
    ev_valid = 1'b1; ev_code = 8'h00;
    step(1'b0, 8'h00, 1'b0, 1);
    ev_valid = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1);
    chk("ev_sent_cnt_zero_code", s_cnt, 32'd1);

    // Back-to-back events with ev_valid held
    do_reset();
    ev_valid = 1'b1; ev_code = 8'h10;
    step(1'b0, 8'h00, 1'b0, 1);
    ev_code = 8'h11;
    step(1'b0, 8'h00, 1'b0, 0);
    step(1'b1, 8'h10, 1'b0, 1);
    ev_code = 8'h12;
    step(1'b0, 8'h00, 1'b0, 0);
    step(1'b1, 8'h11, 1'b0, 1);
    ev_valid = 1'b0; ev_code = 8'h00;
    step(1'b0, 8'h00, 1'b0, 0);
    step(1'b1, 8'h12, 1'b0, 1);
    step(1'b0, 8'h00, 1'b0, 1);
    step(1'b0, 8'h00, 1'b0, 1);
    chk("ev_sent_cnt_b2b", s_cnt, 32'd3);

    // Buffer drain
    do_reset();
    takes_seen = 0;
    bufq.push_back({8'h89, 1'b1}); bufq.push_back({8'hAB, 1'b0});
    bufq.push_back({8'hCD, 1'b0}); bufq.push_back({8'hEF, 1'b1});
    bufq.push_back({8'h76, 1'b0}); bufq.push_back({8'h54, 1'b1});
    bufq.push_back({8'h32, 1'b0}); bufq.push_back({8'h10, 1'b1});
    present_buf();
    for (int i = 0; i < 64 && bufq.size() != 0; i++) step(1'b0, 8'h00, 1'b0, 1);
    chk("buf_drained", 32'(bufq.size()), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 1);
    chk("buf_take_count", takes_seen, 32'd8);

    // Heartbeat collision on the HB_PERIOD=4 instance
    sel_hb = 1'b1;
    do_reset();
    for (int c = 0; c < 34; c++) begin
      bit         ovr;
      logic [7:0] code;
      if (c == 15) begin ev_valid = 1'b1; ev_code = 8'h05; end
      else begin ev_valid = 1'b0; ev_code = 8'h00; end
      ovr  = 1'b0;
      code = 8'h00;
      case (c)
        8, 18, 24, 32: begin ovr = 1'b1; code = 8'h7A; end
        16:            begin ovr = 1'b1; code = 8'h05; end
        default: ;
      endcase
      step(ovr, code, 1'b0, (c == 15) ? 1 : -1);
    end
    chk("hb_ev_sent_cnt", s_cnt, 32'd1);
    sel_hb = 1'b0;

    // Reset while an event is held and a buffer byte is being taken
    do_reset();
    ev_valid = 1'b1; ev_code = 8'h21;
    step(1'b0, 8'h00, 1'b0, 1);
    ev_code = 8'h22;
    step(1'b0, 8'h00, 1'b0, 0);
    step(1'b1, 8'h21, 1'b0, 1);
    ev_valid = 1'b0; ev_code = 8'h00;
    bufq.push_back({8'h5A, 1'b0});
    present_buf();
    mon_en = 1'b0;
    #1;
    chk("pre_rst_take", 32'(s_take), 32'd1);
    chk("pre_rst_ev_ready", 32'(s_ready), 32'd0);
    chk("pre_rst_gt_txdata", 32'(s_data), 32'h21);
    #1 aresetn = 1'b0;
    #1;
    chk("mid_rst_gt_txdata", 32'(s_data), 32'hBC);
    chk("mid_rst_gt_txcharisk", 32'(s_k), 32'd1);
    chk("mid_rst_tx_take", 32'(s_take), 32'd0);
    chk("mid_rst_ev_ready", 32'(s_ready), 32'd1);
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1);
    chk("post_rst_ev_sent_cnt", s_cnt, 32'd0);
    chk("post_rst_buf_taken", 32'(bufq.size()), 32'd0);

    mon_en = 1'b0;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
